// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: drives one column low per cycle, classifies each
// 4-cycle frame, and debounces a single key over DEB_FRAMES identical frames.
module keypad_scan #(
   parameter int DEB_FRAMES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_down
);

   typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

   state_t     state;
   logic [1:0] col_cnt;
   logic [1:0] acc_n;
   logic [3:0] acc_code;
   logic [3:0] cnt;
   logic [3:0] cand;

   logic [3:0] hits;
   logic [2:0] pop;
   logic [2:0] sum;
   logic [1:0] frame_n;
   logic [3:0] hit_code;
   logic [3:0] frame_code;
   logic       f_none;
   logic       f_single;
   logic       cnt_done;

   assign col = ~(4'b0001 << col_cnt);

   // Accumulate this column's sample onto the frame so far; count saturates at 2
   // because the classifier only distinguishes none / one / many.
   always_comb begin
      hits     = ~row;
      pop      = {2'b0, hits[0]} + {2'b0, hits[1]} + {2'b0, hits[2]} + {2'b0, hits[3]};
      sum      = ((col_cnt == 2'd0) ? 3'd0 : {1'b0, acc_n}) + pop;
      frame_n  = (sum >= 3'd2) ? 2'd2 : sum[1:0];
      hit_code = acc_code;
      for (int r = 0; r < 4; r++)
         if (hits[r]) hit_code = {2'(r), col_cnt};
      frame_code = (pop != 3'd0) ? hit_code : acc_code;
      f_none     = (frame_n == 2'd0);
      f_single   = (frame_n == 2'd1);
      cnt_done   = ((cnt + 4'd1) == 4'(DEB_FRAMES));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_cnt   <= 2'd0;
         acc_n     <= 2'd0;
         acc_code  <= 4'd0;
         state     <= IDLE;
         cnt       <= 4'd0;
         cand      <= 4'd0;
         key_code  <= 4'd0;
         key_valid <= 1'b0;
         key_down  <= 1'b0;
      end else begin
         col_cnt   <= col_cnt + 2'd1;
         acc_n     <= frame_n;
         acc_code  <= frame_code;
         key_valid <= 1'b0;
         if (col_cnt == 2'd3) begin
            case (state)
               IDLE: begin
                  if (f_single) begin
                     state <= DEBOUNCE;
                     cand  <= frame_code;
                     cnt   <= 4'd1;
                  end
               end
               DEBOUNCE: begin
                  if (f_single && frame_code == cand) begin
                     if (cnt_done) begin
                        state     <= PRESSED;
                        cnt       <= 4'd0;
                        key_code  <= cand;
                        key_down  <= 1'b1;
                        key_valid <= 1'b1;
                     end else begin
                        cnt <= cnt + 4'd1;
                     end
                  end else begin
                     state <= IDLE;
                     cnt   <= 4'd0;
                  end
               end
               PRESSED: begin
                  if (f_none) begin
                     state <= RELEASE;
                     cnt   <= 4'd1;
                  end
               end
               RELEASE: begin
                  if (f_none) begin
                     if (cnt_done) begin
                        state    <= IDLE;
                        cnt      <= 4'd0;
                        key_down <= 1'b0;
                     end else begin
                        cnt <= cnt + 4'd1;
                     end
                  end else begin
                     // bounce while letting go: treat as still held
                     state <= PRESSED;
                     cnt   <= 4'd0;
                  end
               end
               default: begin
                  state <= IDLE;
                  cnt   <= 4'd0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 The block SHALL have parameter DEB_FRAMES, default 4, giving the number of consecutive identical scan frames required to accept a press or a release (legal range 2..15).
REQ-002 Port clk, input, 1 bit: the single system clock (1 kHz scan clock); all state SHALL be updated on its rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port row, input, 4 bits: keypad row lines, pulled up externally; 0 SHALL mean the key at the driven column is pressed.
REQ-005 Port col, output, 4 bits: keypad column drive, one-hot active-low.
REQ-006 Port key_code, output, 4 bits: code of the accepted key, computed as row_idx*4 + col_idx.
REQ-007 Port key_valid, output, 1 bit: one-cycle pulse when a debounced press is accepted.
REQ-008 Port key_down, output, 1 bit: level, high from acceptance until the debounced release.

Function
REQ-009 A 2-bit column counter SHALL increment every cycle and wrap from 3 to 0; col SHALL equal ~(1 << counter), giving 1110, 1101, 1011, 0111, repeating.
REQ-010 row SHALL be sampled at the rising edge that ends the cycle in which a column is driven; the sample SHALL be attributed to that column.
REQ-011 A frame is the 4 cycles with counter 0..3; the frame accumulator SHALL clear at frame start and record the number of pressed bits and the code of the last pressed bit seen.
REQ-012 At the frame-end edge (counter = 3), the frame SHALL be classified as NONE (0 bits), SINGLE(code) (exactly 1 bit), or MULTI (2 or more bits, in one or several columns).
REQ-013 The FSM states SHALL be IDLE, DEBOUNCE, PRESSED and RELEASE, with a 4-bit frame counter cnt; transitions SHALL occur only at frame-end edges.
REQ-014 In IDLE: on SINGLE(c), go to DEBOUNCE with cand=c and cnt=1; otherwise remain in IDLE.
REQ-015 In DEBOUNCE: on SINGLE(cand), increment cnt; when cnt reaches DEB_FRAMES, go to PRESSED, load key_code=cand, set key_down=1, and pulse key_valid.
REQ-016 In DEBOUNCE: on NONE, MULTI, or SINGLE of a different code, return to IDLE with cnt=0 and no output change.
REQ-017 In PRESSED: on NONE, go to RELEASE with cnt=1; on any other result, remain in PRESSED, with no new key_valid and key_code unchanged.
REQ-018 In RELEASE: on NONE, increment cnt; when cnt reaches DEB_FRAMES, go to IDLE and clear key_down.
REQ-019 In RELEASE: on any key seen, return to PRESSED with cnt=0 and no new key_valid (bounce on release).
REQ-020 key_valid SHALL be high for exactly the one cycle following the accepting frame-end edge; key_down SHALL rise on the same edge.
REQ-021 key_code SHALL hold its last accepted value until the next acceptance, including after release.
REQ-022 Latency: for a clean press stable before frame k starts, key_valid SHALL assert after the end of frame k+DEB_FRAMES-1, which is 4*DEB_FRAMES cycles later; the debounced release latency SHALL be the same.
REQ-023 Only one key at a time SHALL be reported; a second key held during PRESSED SHALL be ignored until full release.

Reset
REQ-024 While rst_n=0, all outputs and state SHALL be forced immediately, regardless of clk.
REQ-025 Reset values SHALL be: column counter=0, col=1110, key_code=0, key_valid=0, key_down=0, state=IDLE, cnt=0, accumulator cleared.
REQ-026 Reset asserted mid-frame or mid-debounce SHALL discard all partial results; after rst_n rises, scanning SHALL restart at column 0 with a fresh frame.

Verification
REQ-027 Reset then no keys for 40 cycles -> col cycles 1110, 1101, 1011, 0111; key_valid and key_down remain 0.
REQ-028 DEB_FRAMES=4; key row 2/col 1 held cleanly from a frame start -> key_valid pulses once, 16 cycles later, with key_code=9 and key_down=1; held 100 more cycles -> no further pulse.
REQ-029 Same key bounces (released in frame 2, pressed again from frame 3) -> key_valid fires only after 4 consecutive clean frames counted from frame 3.
REQ-030 Keys 0 and 5 pressed together from IDLE -> no key_valid; then key 5 released while key 0 stays held -> key_valid with key_code=0 after 4 frames.
REQ-031 Accepted key released with one bounce frame during RELEASE -> key_down stays 1 with no new key_valid, then drops 4 clean NONE frames after the last bounce.
REQ-032 rst_n pulsed low during DEBOUNCE at cnt=3 -> outputs reset immediately; a key held continuously through reset is accepted 16 cycles after rst_n rises.
